imem_load_ctrl: RTL and testbench

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 21 ++
 rtl/imem_load_ctrl.sv | 140 ++++++++++++++
 tb/tb_imem_load_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: defaults, FSM states, beat payload.
package imem_pkg;

    localparam int unsigned IMEM_WORDS_DEF   = 1024;
    localparam int unsigned IDLE_TIMEOUT_DEF = 255;
    localparam int unsigned WORD_CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } ld_state_e;

    // Owner encoding: also the bit position of the requester in the arbiter vectors.
    localparam logic OWN_DBG  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    // A beat may be written only if word aligned and inside the memory.
    function automatic logic beat_addr_ok(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && (32'(addr[31:2]) < words);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not own the last burst wins.
module rr_arb2
    import imem_pkg::*;
(
    input  logic [1:0] req,        // bit 0 debug, bit 1 host
    input  logic       prev_owner, // owner of the previous burst
    output logic [1:0] gnt         // one-hot winner
);

    // Sole requester wins outright; contention alternates away from the previous owner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prev_owner == OWN_DBG) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: arbitrates debug/host loaders, writes imem, releases the core.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS   = IMEM_WORDS_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_data,
    input  logic        dbg_last,
    output logic        dbg_gnt,
    input  logic        host_req,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_data,
    input  logic        host_last,
    output logic        host_gnt,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        core_hold,
    output logic        core_start,
    output logic        load_err,
    output logic [15:0] word_cnt
);

    // Idle counter spans 0 .. IDLE_TIMEOUT-1; the timeout fires on the last of those idle cycles.
    localparam int unsigned IDLE_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);

    ld_state_e             state_q, state_d;
    logic                  owner_q, owner_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  load_err_q, load_err_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  core_hold_q, core_hold_d;
    logic                  core_start_q, core_start_d;

    logic [1:0] arb_gnt;
    beat_t      dbg_beat, host_beat, own_beat;
    logic       addr_ok;

    assign dbg_beat  = '{req: dbg_req,  addr: dbg_addr,  data: dbg_data,  last: dbg_last};
    assign host_beat = '{req: host_req, addr: host_addr, data: host_data, last: host_last};
    assign own_beat  = (owner_q == OWN_HOST) ? host_beat : dbg_beat;
    assign addr_ok   = beat_addr_ok(own_beat.addr, IMEM_WORDS);

    rr_arb2 u_arb (
        .req        ({host_req, dbg_req}),
        .prev_owner (owner_q),
        .gnt        (arb_gnt)
    );

    // Next-state, datapath updates and the zero-latency grant/write outputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        word_cnt_d = word_cnt_q;
        load_err_d = load_err_q;
        idle_cnt_d = idle_cnt_q;
        dbg_gnt    = 1'b0;
        host_gnt   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = {2'b00, own_beat.addr[31:2]};
        mem_wdata  = own_beat.data;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (arb_gnt != 2'b00) begin
                    state_d    = ST_BURST;
                    owner_d    = arb_gnt[1];
                    word_cnt_d = '0;
                    load_err_d = 1'b0;
                    idle_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (own_beat.req && mem_ready) begin
                    dbg_gnt    = (owner_q == OWN_DBG);
                    host_gnt   = (owner_q == OWN_HOST);
                    idle_cnt_d = '0;
                    if (addr_ok) begin
                        mem_we = 1'b1;
                        if (word_cnt_q != '1) begin
                            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                    if (own_beat.last) begin
                        state_d = ST_START;
                    end
                end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                    load_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_hold_d  = (state_d == ST_IDLE) || (state_d == ST_BURST);
        core_start_d = (state_d == ST_START);
    end

    // State and registered outputs; reset parks the core and makes debug win the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_HOST;
            word_cnt_q   <= '0;
            load_err_q   <= 1'b0;
            idle_cnt_q   <= '0;
            core_hold_q  <= 1'b1;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            word_cnt_q   <= word_cnt_d;
            load_err_q   <= load_err_d;
            idle_cnt_q   <= idle_cnt_d;
            core_hold_q  <= core_hold_d;
            core_start_q <= core_start_d;
        end
    end

    assign core_hold  = core_hold_q;
    assign core_start = core_start_q;
    assign load_err   = load_err_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: vector table, directed corner sequences, random bursts.
module tb_imem_load_ctrl;

    localparam int unsigned TB_WORDS = 256;
    localparam int unsigned TB_TMO   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_req, dbg_last, host_req, host_last, mem_ready;
    logic [31:0] dbg_addr, dbg_data, host_addr, host_data;
    logic        dbg_gnt, host_gnt, mem_we, core_hold, core_start, load_err;
    logic [31:0] mem_waddr, mem_wdata;
    logic [15:0] word_cnt;

    imem_load_ctrl #(.IMEM_WORDS(TB_WORDS), .IDLE_TIMEOUT(TB_TMO)) dut (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_last(dbg_last),
        .dbg_gnt(dbg_gnt),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_last(host_last),
        .host_gnt(host_gnt),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .core_hold(core_hold), .core_start(core_start), .load_err(load_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_dbg(input logic r, input logic [31:0] a, input logic [31:0] d, input logic l);
        dbg_req = r; dbg_addr = a; dbg_data = d; dbg_last = l;
    endtask

    task automatic drive_host(input logic r, input logic [31:0] a, input logic [31:0] d, input logic l);
        host_req = r; host_addr = a; host_data = d; host_last = l;
    endtask

    // Vector table: one debug burst, one row per cycle in BURST.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        last;
        logic        gnt;
        logic        we;
        logic [31:0] waddr;
        logic        err;
        logic [15:0] cnt;
    } vec_t;
    vec_t vt[7];

    // Random-test reference: loaders' beats and the spec-level burst order.
    typedef struct { logic [31:0] addr; logic [31:0] data; logic last; logic ok; } tb_beat_t;
    typedef struct { int owner; int nvalid; logic err; } tb_burst_t;

    tb_beat_t  sbeats[2][$];
    tb_burst_t sb[2][$];
    tb_burst_t exp_seq[$];
    tb_beat_t  expw[$];
    tb_beat_t  bt, ew;
    int        ptr[2];
    int        ix[2];
    int        bx[2];
    int        prev, w, bi, starts, nv, len, nb, cat;
    int unsigned wi;
    logic      e, start_seen;
    logic [1:0] g, exp_g;

    initial begin
        vt[0] = '{32'h0000_0000, 32'hA000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0,   1'b0, 16'd1};
        vt[1] = '{32'h0000_0004, 32'hA000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 16'd1};
        vt[2] = '{32'h0000_0004, 32'hA000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 32'd1,   1'b0, 16'd2};
        vt[3] = '{32'h0000_0006, 32'hA000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0,   1'b1, 16'd2};
        vt[4] = '{32'(TB_WORDS * 4), 32'hA000_0004, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 16'd2};
        vt[5] = '{32'(TB_WORDS * 4 - 4), 32'hA000_0005, 1'b1, 1'b0, 1'b1, 1'b1, 32'(TB_WORDS - 1), 1'b1, 16'd3};
        vt[6] = '{32'h0000_0008, 32'hA000_0006, 1'b1, 1'b1, 1'b1, 1'b1, 32'd2,   1'b1, 16'd4};

        rst = 1'b1;
        mem_ready = 1'b0;
        drive_dbg(1'b0, 32'h0, 32'h0, 1'b0);
        drive_host(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_gnts", 32'({host_gnt, dbg_gnt}), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven debug burst from IDLE.
        @(negedge clk);
        drive_dbg(1'b1, vt[0].addr, vt[0].data, vt[0].last);
        mem_ready = 1'b1;
        #1;
        chk("idle_arb_no_gnt", 32'(dbg_gnt), 32'd0);
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_dbg(1'b1, vt[i].addr, vt[i].data, vt[i].last);
            mem_ready = vt[i].rdy;
            #1;
            chk($sformatf("tbl%0d_gnt", i), 32'(dbg_gnt), 32'(vt[i].gnt));
            chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(vt[i].we));
            if (vt[i].we) begin
                chk($sformatf("tbl%0d_waddr", i), mem_waddr, vt[i].waddr);
                chk($sformatf("tbl%0d_wdata", i), mem_wdata, vt[i].data);
            end
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_err", i), 32'(load_err), 32'(vt[i].err));
            chk($sformatf("tbl%0d_cnt", i), 32'(word_cnt), 32'(vt[i].cnt));
        end
        chk("tbl_start", 32'(core_start), 32'd1);
        chk("tbl_start_hold", 32'(core_hold), 32'd0);
        @(negedge clk);
        drive_dbg(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("tbl_run_start", 32'(core_start), 32'd0);
        chk("tbl_run_hold", 32'(core_hold), 32'd0);

        // Timeout: one beat without last, then silence.
        @(negedge clk);
        drive_dbg(1'b1, 32'h20, 32'hB000_0000, 1'b0);
        mem_ready = 1'b1;
        #1;
        chk("run_arb_no_gnt", 32'(dbg_gnt), 32'd0);
        chk("run_hold", 32'(core_hold), 32'd0);
        @(posedge clk);
        #1;
        chk("burst_hold", 32'(core_hold), 32'd1);
        chk("burst_err_clr", 32'(load_err), 32'd0);
        chk("burst_cnt_clr", 32'(word_cnt), 32'd0);
        @(negedge clk);
        #1;
        chk("tmo_beat_gnt", 32'(dbg_gnt), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive_dbg(1'b0, 32'h0, 32'h0, 1'b0);
        start_seen = 1'b0;
        for (int k = 1; k < int'(TB_TMO); k++) begin
            @(posedge clk);
            #1;
            if (core_start) start_seen = 1'b1;
        end
        chk("tmo_err_early", 32'(load_err), 32'd0);
        @(posedge clk);
        #1;
        if (core_start) start_seen = 1'b1;
        chk("tmo_err", 32'(load_err), 32'd1);
        chk("tmo_cnt", 32'(word_cnt), 32'd1);
        chk("tmo_no_start", 32'(start_seen), 32'd0);
        @(negedge clk);
        drive_host(1'b1, 32'h40, 32'hC000_0000, 1'b1);
        #1;
        chk("tmo_idle_no_gnt", 32'(host_gnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("host_gnts", 32'({host_gnt, dbg_gnt}), 32'd2);
        chk("host_waddr", mem_waddr, 32'h10);
        @(posedge clk);
        #1;
        chk("host_start", 32'(core_start), 32'd1);
        chk("host_err_clr", 32'(load_err), 32'd0);
        @(negedge clk);
        drive_host(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);

        // Three-beat burst at full speed from RUN.
        @(negedge clk);
        drive_dbg(1'b1, 32'h0, 32'hD000_0000, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_dbg(1'b1, 32'(i * 4), 32'hD000_0000 + 32'(i), (i == 2));
            #1;
            chk($sformatf("b3_we%0d", i), 32'(mem_we), 32'd1);
            chk($sformatf("b3_waddr%0d", i), mem_waddr, 32'(i));
            @(posedge clk);
        end
        #1;
        chk("b3_start", 32'(core_start), 32'd1);
        chk("b3_cnt", 32'(word_cnt), 32'd3);
        chk("b3_hold", 32'(core_hold), 32'd0);
        @(negedge clk);
        drive_dbg(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("b3_start_one_cycle", 32'(core_start), 32'd0);

        // Reset mid-burst, restart, then a 5-cycle memory stall.
        @(negedge clk);
        drive_dbg(1'b1, 32'h10, 32'hE000_0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive_dbg(1'b1, 32'h14, 32'hE000_0001, 1'b0);
        #1;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        chk("pre_rst_cnt", 32'(word_cnt), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_gnt", 32'(dbg_gnt), 32'd0);
        chk("arst_hold", 32'(core_hold), 32'd1);
        chk("arst_cnt", 32'(word_cnt), 32'd0);
        chk("arst_start", 32'(core_start), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_we_edge", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("restart_gnt", 32'(dbg_gnt), 32'd1);
        @(posedge clk);
        #1;
        chk("restart_cnt", 32'(word_cnt), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_dbg(1'b1, 32'h18, 32'hE000_0002, 1'b1);
            mem_ready = 1'b0;
            #1;
            chk($sformatf("stall%0d_gnt", k), 32'(dbg_gnt), 32'd0);
            chk($sformatf("stall%0d_we", k), 32'(mem_we), 32'd0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("stall_end_we", 32'(mem_we), 32'd1);
        chk("stall_end_waddr", mem_waddr, 32'd6);
        chk("stall_end_wdata", mem_wdata, 32'hE000_0002);
        @(posedge clk);
        #1;
        chk("stall_start", 32'(core_start), 32'd1);
        chk("stall_no_err", 32'(load_err), 32'd0);
        chk("stall_cnt", 32'(word_cnt), 32'd2);
        @(negedge clk);
        drive_dbg(1'b0, 32'h0, 32'h0, 1'b0);

        // Random bursts from both loaders against the burst-order model.
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 2; s++) begin
                sbeats[s].delete();
                sb[s].delete();
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(1, 4);
                    nv = 0;
                    e = 1'b0;
                    for (int j = 0; j < len; j++) begin
                        cat = $urandom_range(0, 9);
                        if (cat == 0) begin
                            wi = $urandom_range(0, TB_WORDS - 1);
                            bt.addr = {wi[29:0], 2'b10};
                        end else if (cat == 1) begin
                            wi = TB_WORDS + $urandom_range(0, 1000);
                            bt.addr = {wi[29:0], 2'b00};
                        end else begin
                            wi = $urandom_range(0, TB_WORDS - 1);
                            bt.addr = {wi[29:0], 2'b00};
                        end
                        bt.ok   = (cat >= 2);
                        bt.data = $urandom;
                        bt.last = (j == len - 1);
                        if (bt.ok) nv++;
                        else e = 1'b1;
                        sbeats[s].push_back(bt);
                    end
                    sb[s].push_back('{s, nv, e});
                end
            end

            exp_seq.delete();
            expw.delete();
            prev = 1;
            ix[0] = 0; ix[1] = 0; bx[0] = 0; bx[1] = 0;
            while (ix[0] < sb[0].size() || ix[1] < sb[1].size()) begin
                if (ix[0] < sb[0].size() && ix[1] < sb[1].size()) w = 1 - prev;
                else w = (ix[0] < sb[0].size()) ? 0 : 1;
                exp_seq.push_back(sb[w][ix[w]]);
                ix[w]++;
                do begin
                    bt = sbeats[w][bx[w]];
                    bx[w]++;
                    if (bt.ok) expw.push_back(bt);
                end while (!bt.last);
                prev = w;
            end

            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            ptr[0] = 0; ptr[1] = 0;
            bi = 0;
            starts = 0;
            for (int cyc = 0; cyc < 2000 && starts < exp_seq.size(); cyc++) begin
                @(negedge clk);
                if (ptr[0] < sbeats[0].size()) drive_dbg(1'b1, sbeats[0][ptr[0]].addr, sbeats[0][ptr[0]].data, sbeats[0][ptr[0]].last);
                else drive_dbg(1'b0, 32'h0, 32'h0, 1'b0);
                if (ptr[1] < sbeats[1].size()) drive_host(1'b1, sbeats[1][ptr[1]].addr, sbeats[1][ptr[1]].data, sbeats[1][ptr[1]].last);
                else drive_host(1'b0, 32'h0, 32'h0, 1'b0);
                mem_ready = ($urandom_range(0, 3) != 0);
                #1;
                g = {host_gnt, dbg_gnt};
                chk("rnd_we_without_gnt", 32'(mem_we & ~(dbg_gnt | host_gnt)), 32'd0);
                if (g != 2'b00) begin
                    exp_g = (bi < exp_seq.size()) ? ((exp_seq[bi].owner == 1) ? 2'b10 : 2'b01) : 2'b00;
                    chk("rnd_owner", 32'(g), 32'(exp_g));
                    w = host_gnt ? 1 : 0;
                    bt = sbeats[w][ptr[w]];
                    chk("rnd_we", 32'(mem_we), 32'(bt.ok));
                    if (mem_we) begin
                        if (expw.size() > 0) begin
                            ew = expw.pop_front();
                            chk("rnd_waddr", mem_waddr, {2'b00, ew.addr[31:2]});
                            chk("rnd_wdata", mem_wdata, ew.data);
                        end else begin
                            chk("rnd_write_extra", 32'(mem_we), 32'd0);
                        end
                    end
                    ptr[w]++;
                    if (bt.last) bi++;
                end
                if (core_start) begin
                    if (starts < exp_seq.size()) begin
                        chk("rnd_cnt", 32'(word_cnt), 32'(exp_seq[starts].nvalid));
                        chk("rnd_err", 32'(load_err), 32'(exp_seq[starts].err));
                    end
                    starts++;
                end
            end
            chk("rnd_bursts_done", 32'(starts), 32'(exp_seq.size()));
            chk("rnd_writes_left", 32'(expw.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
